dcache_mem_slave: RTL and testbench
===================================

// Module: dcache_mem_slave
// PURPOSE
//  Memory-side responder for the data-cache block interface: serves 128-bit line reads/writes
//  over mem_read/mem_write/mem_addr/mem_wdata, answering with a mem_ready pulse and mem_rdata
//  after a programmable latency. Holds a line-addressed storage array.
//  Sits below the data cache as the backing store in core-level simulation and FPGA bring-up.
// PARAMETERS
//  LATENCY   4   cycles from first request cycle to mem_ready pulse; legal range 1..15
//  ADDR_W    8   line-index bits used from mem_addr (array depth = 2**ADDR_W lines of 128 b)
// PORTS
//  clk         in   1    clock, all logic on posedge
//  proc_reset  in   1    synchronous, active-high reset
//  mem_read    in   1    line read request, held high until mem_ready
//  mem_write   in   1    line write request, held high until mem_ready
//  mem_addr    in   28   line address; only [ADDR_W-1:0] used, upper bits ignored (aliasing)
//  mem_wdata   in   128  write line data
//  mem_rdata   out  128  read line data (registered)
//  mem_ready   out  1    one-cycle completion pulse
//  mem_err     out  1    sticky protocol-error flag
// BEHAVIOUR
//  - Reset: mem_ready=0, mem_rdata=0, mem_err=0, state=IDLE, counter=0, all array lines = 0.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: (mem_read|mem_write)=1 -> WAIT, cnt=LATENCY-1; if LATENCY==1 go straight to RESP.
//    WAIT: cnt decrements each cycle; cnt==1 -> RESP. Request dropped (both low) -> IDLE,
//          no access performed (abort).
//    RESP: mem_ready=1 for exactly this cycle; access executes here -> IDLE next cycle.
//  - Timing: request first high in cycle T -> mem_ready high in cycle T+LATENCY, low otherwise.
//  - Address/data are sampled ONLY in the RESP cycle; earlier request cycles may carry an
//    unstable address (requester drives 0 in its first miss cycle) and must be ignored.
//  - Read in RESP: mem_rdata <= array[idx] at the RESP edge; value visible from RESP+1 and held
//    until the next completed read (writes and aborts never change mem_rdata).
//  - Write in RESP: array[idx] <= mem_wdata at the RESP edge; read of same idx completing later
//    returns the new data.
//  - mem_read & mem_write both high in RESP: mem_err set (sticky until reset); write performed,
//    mem_rdata unchanged.
//  - Back-to-back: a request present in the cycle after RESP is a new request (IDLE sees it);
//    write-back followed immediately by allocate read is the normal pattern.
//  - Request in RESP direction changed vs. WAIT (read<->write): the RESP-cycle type wins.
//  - Reset mid-operation (WAIT or RESP): abort, no array update, mem_ready=0 next cycle.
// CONFIGURATION
//  - MEM_SLAVE_STATS_EN defined: adds outputs rd_cnt[31:0], wr_cnt[31:0]; each increments by 1
//    per completed read/write RESP (both-high counts as write), wraps at 2**32, cleared by reset;
//    aborts are not counted.
//  - Undefined: ports rd_cnt/wr_cnt absent; no counter logic; all other behaviour identical.
// TESTING
//  - LATENCY=4: write addr 0x05 data 0x1111..1111 at T=0 -> mem_ready only at T=4; then read
//    0x05 -> mem_ready at T'+4, mem_rdata=0x1111..1111 from T'+5.
//  - First request cycle addr=0, correct addr 0x2A from cycle 1 on; read -> returns array[0x2A],
//    not array[0].
//  - Write 0x0000003 then read 0x1000003 (ADDR_W=8) -> same line returned (aliasing).
//  - Request dropped after 2 cycles -> no mem_ready, array and mem_rdata unchanged; next request
//    completes with full LATENCY.
//  - mem_read & mem_write both high -> mem_err=1 after RESP, write landed; stays 1 until reset.
//  - proc_reset in WAIT of a write to 0x07 -> mem_ready never pulses, read 0x07 later returns 0;
//    with MEM_SLAVE_STATS_EN, 3 reads + 2 writes -> rd_cnt=3, wr_cnt=2.

Source files
------------

// File: rtl/dcache_mem_slave.sv
// rtl/dcache_mem_slave.sv - line-addressed backing store answering data-cache line requests after a fixed latency (optional MEM_SLAVE_STATS_EN adds rd_cnt/wr_cnt)
module dcache_mem_slave #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 8
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         mem_err
`ifdef MEM_SLAVE_STATS_EN
    ,
    output logic [31:0]  rd_cnt,
    output logic [31:0]  wr_cnt
`endif
);

    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT  = 4'(LATENCY - 1);
    localparam bit         SKIP_WAIT = (LATENCY == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [127:0]   rdata_q;
    logic           err_q;
    logic [127:0]   mem_q [DEPTH];

    logic              req;
    logic              in_resp;
    logic              do_write;
    logic              do_read;
    logic [ADDR_W-1:0] idx;

    // Upper address bits alias onto the same lines and are deliberately not decoded.
    generate
        if (ADDR_W < 28) begin : g_addr_alias
            logic unused_addr_bits;
            assign unused_addr_bits = ^mem_addr[27:ADDR_W];
        end
    endgenerate

    assign req      = mem_read | mem_write;
    assign in_resp  = (state_q == S_RESP);
    assign idx      = mem_addr[ADDR_W-1:0];
    // Address and data are only trusted in the response cycle; the RESP-cycle type wins.
    assign do_write = in_resp & mem_write & ~proc_reset;
    assign do_read  = in_resp & mem_read & ~mem_write & ~proc_reset;

    assign mem_ready = in_resp;
    assign mem_rdata = rdata_q;
    assign mem_err   = err_q;

    // Latency sequencer: a dropped request in WAIT aborts without touching storage.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d   = CNT_INIT;
                    state_d = SKIP_WAIT ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, read-data register and sticky error flag.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (do_read) begin
                rdata_q <= mem_q[idx];
            end
            if (in_resp && mem_read && mem_write) begin
                err_q <= 1'b1;
            end
        end
    end

    // Line storage: cleared by reset, written only in the response cycle.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_write) begin
            mem_q[idx] <= mem_wdata;
        end
    end

`ifdef MEM_SLAVE_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;

    // Completed-access counters; a both-high request counts as a write.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (do_read) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (do_write) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_mem_slave.sv
// tb/tb_dcache_mem_slave.sv - randomized self-checking bench for dcache_mem_slave against a transaction-level model
module tb_dcache_mem_slave;

    localparam int LAT    = 4;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic         clk;
    logic         proc_reset;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         mem_err;
`ifdef MEM_SLAVE_STATS_EN
    logic [31:0]  rd_cnt;
    logic [31:0]  wr_cnt;
`endif

    dcache_mem_slave #(
        .LATENCY (LAT),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .mem_err    (mem_err)
`ifdef MEM_SLAVE_STATS_EN
        ,
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Reference model: line array, last completed read, sticky error, access counts.
    logic [127:0] m_mem [DEPTH];
    logic [127:0] m_rdata;
    logic         m_err;
    int unsigned  m_rd;
    int unsigned  m_wr;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_rdata = '0;
        m_err   = 1'b0;
        m_rd    = 0;
        m_wr    = 0;
    endtask

    task automatic model_access(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] d);
        int i;
        i = int'(a) % DEPTH;
        if (wr) begin
            m_mem[i] = d;
            m_wr++;
            if (rd) m_err = 1'b1;
        end else if (rd) begin
            m_rdata = m_mem[i];
            m_rd++;
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle: drive after the edge, check mid-cycle, update the model at the closing edge.
    task automatic cycle(input bit rst, input bit rd, input bit wr,
                         input logic [27:0] a, input logic [127:0] d, input bit exp_rdy);
        proc_reset = rst;
        mem_read   = rd;
        mem_write  = wr;
        mem_addr   = a;
        mem_wdata  = d;
        @(negedge clk);
        check("mem_ready", 128'(mem_ready), 128'(exp_rdy));
        check("mem_rdata", mem_rdata, m_rdata);
        check("mem_err", 128'(mem_err), 128'(m_err));
`ifdef MEM_SLAVE_STATS_EN
        check("rd_cnt", 128'(rd_cnt), 128'(m_rd));
        check("wr_cnt", 128'(wr_cnt), 128'(m_wr));
`endif
        @(posedge clk);
        if (rst) model_clear();
        else if (exp_rdy) model_access(rd, wr, a, d);
        #1;
    endtask

    // A request held for 'hold' cycles (hold >= LAT completes). 'garbage' scrambles address/data
    // before the response cycle (zero address in the first cycle); 'flip' swaps direction before it.
    task automatic txn(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] d,
                       input int hold, input bit garbage, input bit flip);
        bit          full;
        logic [27:0] ga;
        logic [127:0] gd;
        full = (hold >= LAT);
        for (int k = 0; k <= LAT; k++) begin
            if (!full && k >= hold) begin
                cycle(1'b0, 1'b0, 1'b0, 28'($urandom), rnd128(), 1'b0);
            end else if (k < LAT) begin
                ga = garbage ? ((k == 0) ? 28'd0 : 28'($urandom)) : a;
                gd = garbage ? rnd128() : d;
                cycle(1'b0, flip ? wr : rd, flip ? rd : wr, ga, gd, 1'b0);
            end else begin
                cycle(1'b0, rd, wr, a, d, 1'b1);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 28'd0, '0, 1'b0);
    endtask

    task automatic reset_seq();
        cycle(1'b1, 1'b0, 1'b0, 28'd0, '0, 1'b0);
    endtask

    logic [127:0] d0, d1;
    logic [27:0]  ra;
    bit           rrd, rwr;
    int           kind, hold;

    initial begin : main
        n_tests    = 0;
        n_fail     = 0;
        proc_reset = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        proc_reset = 1'b0;

        // Reset state and an idle period
        idle(3);

        // Write 0x05 then read it back with the exact latency
        d0 = {32{4'h1}};
        txn(1'b0, 1'b1, 28'h05, d0, LAT, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 28'h05, '0, LAT, 1'b0, 1'b0);
        idle(1);
        check("read_0x05", mem_rdata, {32{4'h1}});

        // Unstable address before the response cycle is ignored
        d0 = rnd128();
        d1 = rnd128();
        txn(1'b0, 1'b1, 28'h2A, d0, LAT, 1'b0, 1'b0);
        txn(1'b0, 1'b1, 28'h00, d1, LAT, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 28'h2A, '0, LAT, 1'b1, 1'b0);
        idle(1);

        // Aliasing of upper address bits
        txn(1'b0, 1'b1, 28'h0000003, rnd128(), LAT, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 28'h1000003, '0, LAT, 1'b0, 1'b0);

        // Aborted write, then a full read
        txn(1'b0, 1'b1, 28'h05, rnd128(), 2, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 28'h05, '0, LAT, 1'b0, 1'b0);

        // Direction changed between WAIT and RESP
        txn(1'b0, 1'b1, 28'h11, rnd128(), LAT, 1'b0, 1'b1);
        txn(1'b1, 1'b0, 28'h11, '0, LAT, 1'b0, 1'b1);

        // Both high: sticky error, write lands, rdata unchanged
        txn(1'b1, 1'b1, 28'h09, rnd128(), LAT, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 28'h09, '0, LAT, 1'b0, 1'b0);
        idle(2);

        // Reset in WAIT of a write to 0x07
        cycle(1'b0, 1'b0, 1'b1, 28'h07, rnd128(), 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 28'h07, rnd128(), 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 28'h07, rnd128(), 1'b0);
        idle(2);
        txn(1'b1, 1'b0, 28'h07, '0, LAT, 1'b0, 1'b0);

        // Reset in the RESP cycle of a write: no update, no further pulse
        txn(1'b0, 1'b1, 28'h07, rnd128(), LAT, 1'b0, 1'b0);
        for (int k = 0; k < LAT; k++) cycle(1'b0, 1'b0, 1'b1, 28'h08, 128'hABCD, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 28'h08, 128'hABCD, 1'b1);
        idle(2);
        txn(1'b1, 1'b0, 28'h08, '0, LAT, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 28'h07, '0, LAT, 1'b0, 1'b0);

        // Counter scenario: 3 reads and 2 writes after reset
        reset_seq();
        txn(1'b0, 1'b1, 28'h01, rnd128(), LAT, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 28'h01, '0, LAT, 1'b0, 1'b0);
        txn(1'b0, 1'b1, 28'h02, rnd128(), LAT, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 28'h02, '0, LAT, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 28'h01, '0, LAT, 1'b0, 1'b0);
        idle(1);
`ifdef MEM_SLAVE_STATS_EN
        check("rd_cnt_3", 128'(rd_cnt), 128'(3));
        check("wr_cnt_2", 128'(wr_cnt), 128'(2));
`endif

        // Randomized traffic, including back-to-back requests and occasional resets
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 19);
            rrd  = (kind < 8) || (kind == 16);
            wr_sel: begin
                rwr = (kind >= 8 && kind < 15) || (kind == 16) || (kind == 17);
            end
            ra   = {20'($urandom), 3'd0, 1'($urandom), 4'($urandom)};
            hold = (kind == 15 || kind == 17) ? $urandom_range(1, LAT - 1) : LAT;
            if (kind == 15) rrd = 1'b1;
            if (kind >= 18) begin
                if (kind == 19) reset_seq();
                else idle(1);
            end else begin
                txn(rrd, rwr, ra, rnd128(), hold, 1'($urandom), 1'($urandom));
            end
            idle($urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
